// File: rtl/nibble_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nibble_packer_pkg
// Purpose : Shared types and constants for the nibble packer.
// Rev     : 1.0  initial release
// ============================================================================
package nibble_packer_pkg;

    localparam int NIB_W = 4;
    localparam int TAG_W = 8;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    function automatic int slot_lo(input int k);
        return NIB_W * k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_slot_reg.sv
`default_nettype none
// ============================================================================
// Module  : nibble_slot_reg
// Purpose : One 4-bit packing slot; write takes priority over clear.
// Rev     : 1.0  initial release
// ============================================================================
module nibble_slot_reg
    import nibble_packer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic             clr_i,
    input  logic [NIB_W-1:0] d_i,
    output logic [NIB_W-1:0] q_o
);

    logic [NIB_W-1:0] nib_q;

    // Write wins so a nibble accepted during hand-off lands in a cleared word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nib_q <= '0;
        end else if (we_i) begin
            nib_q <= d_i;
        end else if (clr_i) begin
            nib_q <= '0;
        end
    end

    assign q_o = nib_q;

endmodule
`default_nettype wire

// File: rtl/nibble_packer.sv
`default_nettype none
// ============================================================================
// Module  : nibble_packer
// Purpose : Packs NIBBLES 4-bit nibbles LSB-first into a WIDTH-bit word.
//           Optional macro NIBBLE_PACKER_TAG_EN adds an 8-bit word tag on top.
// Rev     : 1.0  initial release
// ============================================================================
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int NIBBLES = 3,
    parameter int WIDTH   = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_nib_i,
    input  logic             in_flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [4:0]       out_count_o
);

`ifdef NIBBLE_PACKER_TAG_EN
    localparam int MIN_W = NIB_W * NIBBLES + TAG_W;
`else
    localparam int MIN_W = NIB_W * NIBBLES;
`endif

    generate
        if (WIDTH < MIN_W || NIBBLES < 1 || NIBBLES > 30) begin : g_param_check
            $error("nibble_packer: illegal NIBBLES/WIDTH combination");
        end
    endgenerate

    state_e     state_q;
    logic [4:0] idx_q;
    logic [4:0] count_q;
    logic [4:0] idx_inc;
    logic       in_xfer;
    logic       out_xfer;

    logic [NIB_W-1:0] slot_q [NIBBLES];
    logic [WIDTH-1:0] out_word;

    assign in_ready_o  = rst_n & ((state_q == FILL) | out_ready_i);
    assign out_valid_o = rst_n & (state_q == FULL);
    assign in_xfer     = in_valid_i & in_ready_o;
    assign out_xfer    = out_valid_o & out_ready_i;
    assign idx_inc     = 5'(idx_q + 5'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_xfer) begin
                        idx_q <= idx_inc;
                        if (idx_inc == 5'(NIBBLES) || in_flush_i) begin
                            state_q <= FULL;
                            count_q <= idx_inc;
                        end
                    end else if (in_flush_i && idx_q != 5'd0) begin
                        state_q <= FULL;
                        count_q <= idx_q;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        if (in_xfer) begin
                            // Hand-off with a fresh nibble already in slot 0.
                            idx_q <= 5'd1;
                            if (NIBBLES == 1 || in_flush_i) begin
                                count_q <= 5'd1;
                            end else begin
                                state_q <= FILL;
                            end
                        end else begin
                            idx_q   <= '0;
                            state_q <= FILL;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < NIBBLES; k++) begin : g_slot
            logic we;
            assign we = in_xfer & (((state_q == FILL) & (idx_q == 5'(k))) |
                                   ((state_q == FULL) & (k == 0)));
            nibble_slot_reg u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .we_i  (we),
                .clr_i (out_xfer),
                .d_i   (in_nib_i),
                .q_o   (slot_q[k])
            );
        end
    endgenerate

`ifdef NIBBLE_PACKER_TAG_EN
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (out_xfer) begin
            tag_q <= tag_q + 8'd1;
        end
    end
`endif

    always_comb begin
        out_word = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            out_word[slot_lo(k) +: NIB_W] = slot_q[k];
        end
`ifdef NIBBLE_PACKER_TAG_EN
        out_word[WIDTH-1 -: TAG_W] = tag_q;
`endif
    end

    assign out_data_o  = out_word;
    assign out_count_o = count_q;

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_o && !out_ready_i) |=> ($stable(out_data_o) && $stable(out_count_o)));

    a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        idx_q <= 5'(NIBBLES));

endmodule
`default_nettype wire

// File: tb/tb_nibble_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_nibble_packer
// Purpose : Directed + random bench for nibble_packer against a queue model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_nibble_packer;

    localparam int NIBBLES = 3;
    localparam int WIDTH   = 128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_nib = 4'h0;
    logic         in_flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [4:0]   out_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_packer #(.NIBBLES(NIBBLES), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_nib_i    (in_nib),
        .in_flush_i  (in_flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_count_o (out_count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected word: nibble payload plus the tag field when the tag build is used.
    function automatic logic [127:0] lit(input logic [127:0] payload, input int tag);
        logic [127:0] r;
        r = payload;
`ifdef NIBBLE_PACKER_TAG_EN
        r[127:120] = 8'(tag);
`else
        if (tag < 0) r = '0;
`endif
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    logic [3:0] m_part[$];
    logic [3:0] m_held[$];
    bit         m_full = 0;
    bit         m_init = 0;
    bit         m_rst  = 0;
    logic [7:0] m_tag  = 0;
    bit         m_rdy;
    bit         m_inx;

    function automatic logic [127:0] pack_held();
        logic [127:0] r;
        r = '0;
        foreach (m_held[i]) r[4*i +: 4] = m_held[i];
`ifdef NIBBLE_PACKER_TAG_EN
        r[127:120] = m_tag;
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init = 1; m_rst = 1; m_full = 0; m_tag = 0;
            m_part.delete(); m_held.delete();
        end else begin
            m_rst = 0;
            m_rdy = m_full ? out_ready : 1'b1;
            m_inx = in_valid && m_rdy;
            if (!(m_full && !out_ready)) begin
                if (m_full) begin
                    m_full = 0;
                    m_tag  = m_tag + 8'd1;
                    m_part.delete();
                end
                if (m_inx) m_part.push_back(in_nib);
                if (m_part.size() == NIBBLES || (in_flush && m_part.size() > 0)) begin
                    m_held = m_part;
                    m_part.delete();
                    m_full = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_valid", {127'd0, out_valid}, {127'd0, (m_full && rst_n)});
            chk("model_ready", {127'd0, in_ready},
                {127'd0, (rst_n && (m_full ? out_ready : 1'b1))});
            if (m_rst) begin
                chk("model_rst_data", out_data, 128'd0);
                chk("model_rst_count", {123'd0, out_count}, 128'd0);
            end else if (m_full && rst_n) begin
                chk("model_data", out_data, pack_held());
                chk("model_count", {123'd0, out_count}, 128'(m_held.size()));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic v, input logic [3:0] n,
                         input logic f, input logic o);
        @(posedge clk);
        #1;
        rst_n = r; in_valid = v; in_nib = n; in_flush = f; out_ready = o;
        #1;
    endtask

    initial begin
        logic [127:0] hold_data;

        repeat (3) drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("reset_valid", {127'd0, out_valid}, 128'd0);
        chk("reset_data", out_data, 128'd0);
        chk("reset_count", {123'd0, out_count}, 128'd0);

        // Three nibbles, consumer stalled.
        drive(1, 1, 4'h1, 0, 0);
        drive(1, 1, 4'h2, 0, 0);
        drive(1, 1, 4'h3, 0, 0);
        chk("t1_not_yet_valid", {127'd0, out_valid}, 128'd0);
        drive(1, 0, 4'h0, 0, 0);
        chk("t1_valid", {127'd0, out_valid}, 128'd1);
        chk("t1_data", out_data, lit(128'h321, 0));
        chk("t1_count", {123'd0, out_count}, 128'd3);
        chk("t1_ready_low", {127'd0, in_ready}, 128'd0);
        chk("t1_model_pin", pack_held(), lit(128'h321, 0));
        hold_data = out_data;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 4'hF, 0, 0);
            chk("t4_no_accept", {127'd0, in_ready}, 128'd0);
            chk("t4_stable", out_data, hold_data);
        end
        drive(1, 0, 4'h0, 0, 1);
        chk("t1_take_valid", {127'd0, out_valid}, 128'd1);

        // Continuous stream, two words back to back.
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 4'(i + 1), 0, 1);
            chk("t2_no_bubble", {127'd0, in_ready}, 128'd1);
            if (i == 3) chk("t2_word0", out_data, lit(128'h321, 1));
        end
        drive(1, 0, 4'h0, 0, 0);
        chk("t2_word1_valid", {127'd0, out_valid}, 128'd1);
        chk("t2_word1", out_data, lit(128'h654, 2));
        drive(1, 0, 4'h0, 0, 1);

        // Flush of a partial word, then a flush at idx=0.
        drive(1, 1, 4'hA, 0, 0);
        drive(1, 1, 4'hB, 0, 0);
        drive(1, 0, 4'h0, 1, 0);
        drive(1, 0, 4'h0, 0, 0);
        chk("t3_flush_valid", {127'd0, out_valid}, 128'd1);
        chk("t3_flush_data", out_data, lit(128'h0BA, 3));
        chk("t3_flush_count", {123'd0, out_count}, 128'd2);
        drive(1, 0, 4'h0, 0, 1);
        drive(1, 0, 4'h0, 1, 0);
        drive(1, 0, 4'h0, 0, 0);
        chk("t3_empty_flush", {127'd0, out_valid}, 128'd0);

        // Mid-word reset.
        drive(1, 1, 4'h1, 0, 0);
        drive(1, 1, 4'h2, 0, 0);
        drive(0, 0, 4'h0, 0, 0);
        chk("t5_rst_ready", {127'd0, in_ready}, 128'd0);
        drive(1, 1, 4'h7, 0, 0);
        chk("t5_after_valid", {127'd0, out_valid}, 128'd0);
        chk("t5_after_data", out_data, 128'd0);
        chk("t5_after_count", {123'd0, out_count}, 128'd0);
        drive(1, 1, 4'h8, 0, 0);
        drive(1, 1, 4'h9, 0, 0);
        drive(1, 0, 4'h0, 0, 0);
        chk("t5_word", out_data, lit(128'h987, 0));
        chk("t5_count", {123'd0, out_count}, 128'd3);
        drive(1, 0, 4'h0, 0, 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                  4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
        end

`ifdef NIBBLE_PACKER_TAG_EN
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int w = 0; w <= 257; w++) begin
            drive(1, 1, 4'(w), 1, 1);
            if (w > 0) chk("tag_seq", {120'd0, out_data[127:120]}, 128'(8'(w - 1)));
        end
`endif
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Upstream feeder for the 128-bit nibble-sliced consumer stage. That stage slices its input as {i2, i1, i0}, with i0 in the least significant 4 bits.
- Accepts a stream of 4-bit nibbles over a valid/ready handshake and packs NIBBLES of them, LSB-first, into one 128-bit word.
- Presents each word on a valid/ready output and holds it stable until it is taken.
- A flush sideband emits a partially filled word.

Parameters:
- NIBBLES, 3, nibbles per word (1..30); slot k occupies out_data[4k+3:4k].
- WIDTH, 128, output word width; must be at least 4*NIBBLES (plus 8 when the tag feature is enabled).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  nibble offered.
- in_ready  output  1  packer can accept a nibble.
- in_nib  input  4  nibble data.
- in_flush  input  1  emit the current partial word (sideband, single-cycle).
- out_valid  output  1  word available.
- out_ready  input  1  consumer takes the word.
- out_data  output  WIDTH  packed word.
- out_count  output  5  number of valid nibbles in out_data (1..NIBBLES).

Behaviour:
- Reset is sampled only on a clk edge. While rst_n=0:
  - state=FILL, idx=0
  - out_valid=0, out_data=0, out_count=0
  - in_ready=0 (forced)
  - tag=0
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready. in_nib is ignored when in_valid=0.
- States:
  - FILL: out_valid=0, in_ready=1.
  - FULL: out_valid=1, in_ready=out_ready.
- FILL behaviour:
  - An in-transfer writes in_nib into slot idx and increments idx.
  - When idx reaches NIBBLES, go to FULL on the next edge with out_count=NIBBLES. Latency from the last accepted nibble to out_valid is 1 cycle.
- Flush:
  - In FILL with idx>0 (after counting any same-cycle in-transfer): go to FULL with out_count=idx. Unfilled slots read 0.
  - In FILL with idx=0 and no same-cycle in-transfer: ignored.
  - In FULL: ignored. It is not queued.
- FULL behaviour:
  - out_data and out_count are held stable until the out-transfer.
  - On an out-transfer without an in-transfer: go to FILL, idx=0, all slots cleared to 0.
- Same-cycle out-transfer and in-transfer in FULL:
  - The old word is handed off.
  - The new nibble lands in slot 0 of a cleared word, idx=1, state=FILL.
  - If NIBBLES=1 or in_flush=1: stay in FULL with the new word.
  - No bubble, no data loss.
- Upper bits [WIDTH-1:4*NIBBLES] are always 0, except tag bits when the tag feature is enabled.
- A mid-operation reset discards any partial or held word; no output transfer occurs in the reset cycle.
- Assertions:
  - out_data and out_count stable while out_valid & !out_ready.
  - idx ≤ NIBBLES.

Optional Feature:
- Macro: NIBBLE_PACKER_TAG_EN.
- Defined:
  - out_data[WIDTH-1:WIDTH-8] carries an 8-bit sequence tag equal to the number of words emitted since reset, mod 256.
  - tag increments on each out-transfer; it wraps 255→0.
  - The elaboration check becomes WIDTH ≥ 4*NIBBLES+8.
- Undefined: those bits are 0 and no tag register exists.

Decomposition:
- Package nibble_packer_pkg:
  - state enum {FILL, FULL}
  - NIB_W=4, TAG_W=8
  - function slot_lo(k)=4*k
- Sub-module nibble_slot_reg: one 4-bit slot with write-enable and synchronous clear, instantiated NIBBLES times via generate.
- The top level holds the FSM, idx counter, out_count and tag.

Test Plan:
- Reset, then nibbles 0x1, 0x2, 0x3 on consecutive cycles with out_ready=0:
  - out_valid rises 1 cycle after the third nibble.
  - out_data[11:0]=0x321, out_count=3, upper bits 0.
  - in_ready=0 until out_ready.
- Continuous stream 0x1..0x6 with out_ready=1: two words 0x321 and 0x654, emitted back-to-back with no in_ready bubble.
- Nibbles 0xA, 0xB, then in_flush: word 0x0BA, out_count=2. A flush at idx=0 produces no word.
- Hold out_ready=0 for 5 cycles in FULL while in_valid=1: no nibble accepted, and out_data is stable throughout.
- Drive rst_n=0 for one cycle after 2 nibbles: out_valid=0, state=FILL, idx=0. The next 3 nibbles 0x7, 0x8, 0x9 yield 0x987.
- With NIBBLE_PACKER_TAG_EN, emit 257 words: tags 0..255 then 0 in bits [127:120].
